// File: rtl/uart_autobaud_pkg.sv
// Shared types and widths for the UART auto-baud controller.
package uart_autobaud_pkg;

    localparam int unsigned BAUD_W = 13;
    localparam int unsigned FRAC_W = 3;
    localparam int unsigned CNT_W  = 21;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_TOO_FAST = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitStart,
        StMeasure,
        StCompute,
        StLocked,
        StError
    } state_t;

endpackage

// File: rtl/uart_rx_edge_sync.sv
// rx synchronizer with optional 3-tap majority filter (AUTOBAUD_GLITCH_FILTER_EN) and fall detect.
module uart_rx_edge_sync (
    input  logic clk,
    input  logic aresetn,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] tap_q;
    logic       filt_q;

    // Majority over the synced sample and two older taps: 2 clk delay on both edges.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tap_q  <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            tap_q  <= {tap_q[0], sync_q[1]};
            filt_q <= (sync_q[1] & tap_q[0]) | (sync_q[1] & tap_q[1]) | (tap_q[0] & tap_q[1]);
        end
    end

    assign rx_s = filt_q;
`else
    assign rx_s = sync_q[1];
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= rx_s;
        end
    end

    assign fall = prev_q & ~rx_s;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud measurement on a 0x55 sync char, or manual pass-through of the baud registers.
// Optional rx glitch filter enabled by defining AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud_ctrl
    import uart_autobaud_pkg::*;
#(
    parameter logic [23:0] TIMEOUT  = 24'hFFFFFF,
    parameter int unsigned IDLE_MIN = 16
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              rx,
    input  logic              auto_en,
    input  logic              start,
    input  logic [BAUD_W-1:0] baud_val_cfg,
    input  logic [FRAC_W-1:0] baud_frac_cfg,
    output logic [BAUD_W-1:0] baud_val,
    output logic [FRAC_W-1:0] baud_val_fraction,
    output logic              busy,
    output logic              locked,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [15:0] IDLE_LAST = 16'(IDLE_MIN - 1);

    state_t            state_q, state_d;
    logic [23:0]       timer_q, timer_d;
    logic [15:0]       idle_q, idle_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [1:0]        edges_q, edges_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic              busy_q, busy_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic              rx_s;
    logic              fall;

    uart_rx_edge_sync u_edge_sync (
        .clk     (clk),
        .aresetn (aresetn),
        .rx      (rx),
        .rx_s    (rx_s),
        .fall    (fall)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idle_d   = idle_q;
        n_d      = n_q;
        edges_d  = edges_q;
        baud_d   = baud_q;
        frac_d   = frac_q;
        busy_d   = busy_q;
        locked_d = locked_q;
        err_d    = err_q;
        code_d   = code_q;

        if (!auto_en) begin
            state_d  = StIdle;
            baud_d   = baud_val_cfg;
            frac_d   = baud_frac_cfg;
            busy_d   = 1'b0;
            locked_d = 1'b0;
            err_d    = 1'b0;
            code_d   = ERR_NONE;
        end else begin
            case (state_q)
                StIdle, StLocked, StError: begin
                    if (start) begin
                        state_d  = StArm;
                        busy_d   = 1'b1;
                        locked_d = 1'b0;
                        err_d    = 1'b0;
                        code_d   = ERR_NONE;
                        timer_d  = '0;
                        idle_d   = '0;
                    end
                end
                StArm: begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == TIMEOUT) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                    end else if (rx_s) begin
                        if (idle_q == IDLE_LAST) begin
                            state_d = StWaitStart;
                        end else begin
                            idle_d = idle_q + 16'd1;
                        end
                    end else begin
                        idle_d = '0;
                    end
                end
                StWaitStart: begin
                    timer_d = timer_q + 24'd1;
                    if (timer_q == TIMEOUT) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                    end else if (fall) begin
                        n_d     = '0;
                        edges_d = '0;
                        state_d = StMeasure;
                    end
                end
                StMeasure: begin
                    // The 4th fall also counts its own cycle, so N spans exactly 8 bit periods.
                    n_d = n_q + 21'd1;
                    if (n_d[CNT_W-1]) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = ERR_OVERFLOW;
                    end else if (fall) begin
                        if (edges_q == 2'd3) begin
                            state_d = StCompute;
                        end else begin
                            edges_d = edges_q + 2'd1;
                        end
                    end
                end
                StCompute: begin
                    if (n_q[19:7] == '0) begin
                        state_d = StError;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = ERR_TOO_FAST;
                    end else begin
                        baud_d   = n_q[19:7] - 13'd1;
                        frac_d   = n_q[6:4];
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = StLocked;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            idle_q   <= '0;
            n_q      <= '0;
            edges_q  <= '0;
            baud_q   <= '0;
            frac_q   <= '0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idle_q   <= idle_d;
            n_q      <= n_d;
            edges_q  <= edges_d;
            baud_q   <= baud_d;
            frac_q   <= frac_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    assign baud_val          = baud_q;
    assign baud_val_fraction = frac_q;
    assign busy              = busy_q;
    assign locked            = locked_q;
    assign err               = err_q;
    assign err_code          = code_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: vector tables, directed corner cases, random frames.
module tb_uart_autobaud_ctrl;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        rx;
    logic        auto_en;
    logic        start;
    logic [12:0] baud_val_cfg;
    logic [2:0]  baud_frac_cfg;
    logic [12:0] baud_val;
    logic [2:0]  baud_val_fraction;
    logic        busy;
    logic        locked;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_baud;
    logic [2:0]  m_frac;

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    localparam int LAT = 6;
    localparam logic [12:0] GL_BAUD = 13'd2;
    localparam logic [2:0]  GL_FRAC = 3'd1;
`else
    localparam int LAT = 4;
    localparam logic [12:0] GL_BAUD = 13'd1;
    localparam logic [2:0]  GL_FRAC = 3'd6;
`endif

    typedef struct {
        logic [12:0] cfg;
        logic [2:0]  fr;
        logic [12:0] exp_baud;
        logic [2:0]  exp_frac;
    } man_vec_t;

    typedef struct {
        int          t;
        logic [12:0] exp_baud;
        logic [2:0]  exp_frac;
        logic        exp_lock;
        logic [1:0]  exp_code;
    } frame_vec_t;

    man_vec_t   mans[4];
    frame_vec_t frames[5];

    uart_autobaud_ctrl #(
        .TIMEOUT  (24'd1000),
        .IDLE_MIN (16)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .rx                (rx),
        .auto_en           (auto_en),
        .start             (start),
        .baud_val_cfg      (baud_val_cfg),
        .baud_frac_cfg     (baud_frac_cfg),
        .baud_val          (baud_val),
        .baud_val_fraction (baud_val_fraction),
        .busy              (busy),
        .locked            (locked),
        .err               (err),
        .err_code          (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        cyc(30);
    endtask

    task automatic drive_to_bit7(input int t);
        logic [7:0] ch;
        ch = 8'h55;
        rx = 1'b0;
        cyc(t);
        for (int i = 0; i < 7; i++) begin
            rx = ch[i];
            cyc(t);
        end
        rx = ch[7];
    endtask

    task automatic send_frame(input int t);
        drive_to_bit7(t);
        cyc(t);
        rx = 1'b1;
        cyc(t);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            cyc(1);
            k++;
        end
        check({name, "_done"}, 32'(busy), 0);
    endtask

    task automatic check_result(input string name, input logic [12:0] b, input logic [2:0] f,
                                input logic lk, input logic [1:0] code);
        check({name, "_baud"}, 32'(baud_val), 32'(b));
        check({name, "_frac"}, 32'(baud_val_fraction), 32'(f));
        check({name, "_locked"}, 32'(locked), 32'(lk));
        check({name, "_err"}, 32'(err), 32'(code != 2'd0));
        check({name, "_code"}, 32'(err_code), 32'(code));
    endtask

    // Reference: N = 8 bit periods; baud + frac/8 = N/128 - 1, truncated to eighths.
    task automatic model_frame(input int t, output logic [12:0] b, output logic [2:0] f,
                               output logic lk, output logic [1:0] code);
        int n;
        n = 8 * t;
        if (n < 128) begin
            b = m_baud;
            f = m_frac;
            lk = 1'b0;
            code = 2'd3;
        end else begin
            b = 13'(n / 128 - 1);
            f = 3'((n % 128) / 16);
            lk = 1'b1;
            code = 2'd0;
        end
    endtask

    initial begin
        logic [12:0] eb;
        logic [2:0]  ef;
        logic        el;
        logic [1:0]  ec;
        int          lat;
        int          k;
        int          t;

        mans[0] = '{13'd26, 3'd3, 13'd26, 3'd3};
        mans[1] = '{13'd0, 3'd0, 13'd0, 3'd0};
        mans[2] = '{13'd8191, 3'd7, 13'd8191, 3'd7};
        mans[3] = '{13'd100, 3'd5, 13'd100, 3'd5};

        frames[0] = '{434, 13'd26, 3'd1, 1'b1, 2'd0};
        frames[1] = '{10, 13'd26, 3'd1, 1'b0, 2'd3};
        frames[2] = '{16, 13'd0, 3'd0, 1'b1, 2'd0};
        frames[3] = '{15, 13'd0, 3'd0, 1'b0, 2'd3};
        frames[4] = '{100, 13'd5, 3'd2, 1'b1, 2'd0};

        aresetn = 1'b0;
        rx = 1'b1;
        auto_en = 1'b0;
        start = 1'b0;
        baud_val_cfg = 13'd55;
        baud_frac_cfg = 3'd2;
        cyc(2);
        check_result("reset", 13'd0, 3'd0, 1'b0, 2'd0);
        check("reset_busy", 32'(busy), 0);
        aresetn = 1'b1;
        cyc(1);

        for (int i = 0; i < 4; i++) begin
            baud_val_cfg = mans[i].cfg;
            baud_frac_cfg = mans[i].fr;
            cyc(1);
            check_result("manual", mans[i].exp_baud, mans[i].exp_frac, 1'b0, 2'd0);
            check("manual_busy", 32'(busy), 0);
        end
        m_baud = 13'd100;
        m_frac = 3'd5;

        auto_en = 1'b1;
        baud_val_cfg = 13'd7;
        cyc(2);
        check_result("auto_hold", m_baud, m_frac, 1'b0, 2'd0);

        for (int i = 0; i < 5; i++) begin
            arm();
            send_frame(frames[i].t);
            wait_done("frame");
            check_result("frame", frames[i].exp_baud, frames[i].exp_frac,
                         frames[i].exp_lock, frames[i].exp_code);
            m_baud = frames[i].exp_baud;
            m_frac = frames[i].exp_frac;
        end

        // Lock latency measured from the driven bit-7 falling edge.
        arm();
        drive_to_bit7(20);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (locked && lat == 0) lat = i;
        end
        check("lock_latency", 32'(lat), 32'(LAT));
        cyc(12);
        rx = 1'b1;
        cyc(20);
        check_result("latency_frame", 13'd0, 3'd2, 1'b1, 2'd0);
        m_baud = 13'd0;
        m_frac = 3'd2;

        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                auto_en = 1'b0;
                baud_val_cfg = 13'($urandom);
                baud_frac_cfg = 3'($urandom);
                cyc(1);
                check_result("rand_manual", baud_val_cfg, baud_frac_cfg, 1'b0, 2'd0);
                m_baud = baud_val_cfg;
                m_frac = baud_frac_cfg;
                auto_en = 1'b1;
                cyc(1);
            end
            t = int'($urandom_range(8, 300));
            arm();
            send_frame(t);
            wait_done("rand");
            model_frame(t, eb, ef, el, ec);
            check_result("rand_frame", eb, ef, el, ec);
            m_baud = eb;
            m_frac = ef;
        end

        arm();
        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(63);
        send_frame(50);
        wait_done("glitch");
        check_result("glitch", GL_BAUD, GL_FRAC, 1'b1, 2'd0);

        arm();
        rx = 1'b0;
        cyc(30);
        rx = 1'b1;
        cyc(30);
        check("abort_busy_pre", 32'(busy), 1);
        auto_en = 1'b0;
        baud_val_cfg = 13'd777;
        baud_frac_cfg = 3'd4;
        cyc(1);
        check("abort_busy", 32'(busy), 0);
        check_result("abort", 13'd777, 3'd4, 1'b0, 2'd0);
        auto_en = 1'b1;
        cyc(2);

        arm();
        rx = 1'b0;
        cyc(30);
        rx = 1'b1;
        cyc(10);
        check("rst_busy_pre", 32'(busy), 1);
        aresetn = 1'b0;
        #1;
        check_result("async_reset", 13'd0, 3'd0, 1'b0, 2'd0);
        check("async_reset_busy", 32'(busy), 0);
        cyc(2);
        aresetn = 1'b1;
        cyc(2);

        start = 1'b1;
        cyc(1);
        start = 1'b0;
        k = 1;
        while (!err && k < 1200) begin
            cyc(1);
            k++;
        end
        check("timeout_window", 32'(k >= 995 && k <= 1010), 1);
        check("timeout_busy", 32'(busy), 0);
        check_result("timeout", 13'd0, 3'd0, 1'b0, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
